// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the ALU/LSU issuers and the register-file write arbiter.
// The arbiter side is the slave modport; the issuer/observer side is the master.
interface regfile_wb_arbiter_if;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;

  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;

  logic        register_write_valid;
  logic [4:0]  write_reg;
  logic [31:0] reg_write_data;
  logic [1:0]  alu_pending;
  logic [1:0]  lsu_pending;
  logic        idle;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    input  alu_ready, lsu_ready,
    input  register_write_valid, write_reg, reg_write_data,
    input  alu_pending, lsu_pending, idle
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    output alu_ready, lsu_ready,
    output register_write_valid, write_reg, reg_write_data,
    output alu_pending, lsu_pending, idle
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-requester register-file writeback arbiter, each requester behind a 2-entry FIFO.
// Define WB_RR_ARB_EN for round-robin arbitration; default is fixed ALU priority.
module regfile_wb_arbiter (
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  wb
);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

  localparam int ALU = 0;
  localparam int LSU = 1;

  wb_entry_t   mem [2][2];
  wb_entry_t   req_entry [2];
  logic [1:0]  count_q [2];
  logic [1:0]  wr_ptr_q;
  logic [1:0]  rd_ptr_q;
  logic [1:0]  req_valid;
  logic [1:0]  ready;
  logic [1:0]  push;
  logic [1:0]  pop;
  logic [1:0]  nonempty;
  wb_entry_t   pop_entry;
  wb_entry_t   out_q;
  logic        write_valid_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    req_valid      = {wb.lsu_valid, wb.alu_valid};
    req_entry[ALU] = '{rd: wb.alu_rd, data: wb.alu_data};
    req_entry[LSU] = '{rd: wb.lsu_rd, data: wb.lsu_data};
    ready          = 2'b00;
    push           = 2'b00;
    nonempty       = 2'b00;
    for (int i = 0; i < 2; i++) begin
      // Ready comes from the registered count alone, so a full queue never passes through.
      ready[i]    = (count_q[i] < 2'd2);
      // Register 31 is write-protected: the handshake completes but nothing is queued.
      push[i]     = req_valid[i] && ready[i] && (req_entry[i].rd != 5'd31);
      nonempty[i] = (count_q[i] != 2'd0);
    end
  end

`ifdef WB_RR_ARB_EN
  typedef enum logic {GRANT_ALU = 1'b0, GRANT_LSU = 1'b1} grant_t;

  grant_t last_grant_q;
  grant_t last_grant_d;

  always_comb begin
    pop          = 2'b00;
    last_grant_d = last_grant_q;
    if (nonempty[ALU] && nonempty[LSU]) begin
      pop = (last_grant_q == GRANT_LSU) ? 2'b01 : 2'b10;
    end else begin
      pop = nonempty;
    end
    if (pop[ALU]) begin
      last_grant_d = GRANT_ALU;
    end else if (pop[LSU]) begin
      last_grant_d = GRANT_LSU;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= GRANT_LSU;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  always_comb begin
    pop = 2'b00;
    if (nonempty[ALU]) begin
      pop[ALU] = 1'b1;
    end else if (nonempty[LSU]) begin
      pop[LSU] = 1'b1;
    end
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= 2'b00;
      rd_ptr_q <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        count_q[i] <= 2'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wr_ptr_q[i] <= ~wr_ptr_q[i];
        if (pop[i])  rd_ptr_q[i] <= ~rd_ptr_q[i];
        case ({push[i], pop[i]})
          2'b10:   count_q[i] <= count_q[i] + 2'd1;
          2'b01:   count_q[i] <= count_q[i] - 2'd1;
          default: count_q[i] <= count_q[i];
        endcase
      end
    end
  end

  // NOTE: entry storage is deliberately not reset; the counts alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push[ALU]) mem[ALU][wr_ptr_q[ALU]] <= req_entry[ALU];
    if (push[LSU]) mem[LSU][wr_ptr_q[LSU]] <= req_entry[LSU];
  end

  assign pop_entry = pop[ALU] ? mem[ALU][rd_ptr_q[ALU]] : mem[LSU][rd_ptr_q[LSU]];

  // Write port is registered: the strobe lasts one cycle, rd/data hold between writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_valid_q <= 1'b0;
      out_q         <= '0;
    end else begin
      write_valid_q <= |pop;
      if (|pop) out_q <= pop_entry;
    end
  end

  assign wb.alu_ready            = ready[ALU];
  assign wb.lsu_ready            = ready[LSU];
  assign wb.alu_pending          = count_q[ALU];
  assign wb.lsu_pending          = count_q[LSU];
  assign wb.register_write_valid = write_valid_q;
  assign wb.write_reg            = out_q.rd;
  assign wb.reg_write_data       = out_q.data;
  assign wb.idle = (count_q[ALU] == 2'd0) && (count_q[LSU] == 2'd0) && !write_valid_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter; expectations follow WB_RR_ARB_EN.
module tb_regfile_wb_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if wb();

  regfile_wb_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .wb    (wb)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_strobe(input string tag, input logic [4:0] rd, input logic [31:0] data);
    check({tag, ".wv"},   32'(wb.register_write_valid), 32'd1);
    check({tag, ".rd"},   32'(wb.write_reg),            32'(rd));
    check({tag, ".data"}, wb.reg_write_data,            data);
  endtask

  task automatic drive_alu(input logic v, input logic [4:0] rd, input logic [31:0] data);
    wb.alu_valid = v;
    wb.alu_rd    = rd;
    wb.alu_data  = data;
  endtask

  task automatic drive_lsu(input logic v, input logic [4:0] rd, input logic [31:0] data);
    wb.lsu_valid = v;
    wb.lsu_rd    = rd;
    wb.lsu_data  = data;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    drive_alu(1'b0, 5'd0, 32'd0);
    drive_lsu(1'b0, 5'd0, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [4:0]  a_rd (input int i); return 5'(1 + i);       endfunction
  function automatic logic [31:0] a_dat(input int i); return 32'h0A00 + 32'(i); endfunction
  function automatic logic [4:0]  l_rd (input int i); return 5'(20 + i);      endfunction
  function automatic logic [31:0] l_dat(input int i); return 32'h0B00 + 32'(i); endfunction

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   ai;
    int   li;
    int   j;
    logic acc_a;
    logic acc_l;

    reset = 1'b1;
    drive_alu(1'b0, 5'd0, 32'd0);
    drive_lsu(1'b0, 5'd0, 32'd0);
    @(negedge clk);
    check("rst.wv",       32'(wb.register_write_valid), 32'd0);
    check("rst.rd",       32'(wb.write_reg),            32'd0);
    check("rst.data",     wb.reg_write_data,            32'd0);
    check("rst.alu_pend", 32'(wb.alu_pending),          32'd0);
    check("rst.lsu_pend", 32'(wb.lsu_pending),          32'd0);
    check("rst.alu_rdy",  32'(wb.alu_ready),            32'd1);
    check("rst.lsu_rdy",  32'(wb.lsu_ready),            32'd1);
    check("rst.idle",     32'(wb.idle),                 32'd1);
    @(negedge clk);
    reset = 1'b0;

    // Single ALU write: strobe exactly one cycle, two edges after accept.
    drive_alu(1'b1, 5'd10, 32'h20);
    @(negedge clk);
    drive_alu(1'b0, 5'd0, 32'd0);
    check("t1.pend1", 32'(wb.alu_pending),          32'd1);
    check("t1.wv0",   32'(wb.register_write_valid), 32'd0);
    check("t1.busy",  32'(wb.idle),                 32'd0);
    @(negedge clk);
    check_strobe("t1.strobe", 5'd10, 32'h20);
    check("t1.pend0", 32'(wb.alu_pending), 32'd0);
    @(negedge clk);
    check("t1.wv_off",  32'(wb.register_write_valid), 32'd0);
    check("t1.hold_rd", 32'(wb.write_reg),            32'd10);
    check("t1.hold_dt", wb.reg_write_data,            32'h20);
    check("t1.idle",    32'(wb.idle),                 32'd1);

    // Simultaneous requests right after reset: ALU first in both builds.
    apply_reset();
    drive_alu(1'b1, 5'd5, 32'h55);
    drive_lsu(1'b1, 5'd6, 32'h66);
    @(negedge clk);
    drive_alu(1'b0, 5'd0, 32'd0);
    drive_lsu(1'b0, 5'd0, 32'd0);
    check("t2.alu_pend", 32'(wb.alu_pending), 32'd1);
    check("t2.lsu_pend", 32'(wb.lsu_pending), 32'd1);
    @(negedge clk);
    check_strobe("t2.first", 5'd5, 32'h55);
    @(negedge clk);
    check_strobe("t2.second", 5'd6, 32'h66);
    @(negedge clk);
    check("t2.wv_off", 32'(wb.register_write_valid), 32'd0);
    check("t2.idle",   32'(wb.idle),                 32'd1);

    // Write to r31: accepted, dropped, no strobe.
    drive_lsu(1'b1, 5'd31, 32'hDEAD);
    check("t3.ready", 32'(wb.lsu_ready), 32'd1);
    @(negedge clk);
    drive_lsu(1'b0, 5'd0, 32'd0);
    check("t3.pend", 32'(wb.lsu_pending),          32'd0);
    check("t3.wv0",  32'(wb.register_write_valid), 32'd0);
    @(negedge clk);
    check("t3.wv1",  32'(wb.register_write_valid), 32'd0);
    check("t3.idle", 32'(wb.idle),                 32'd1);

    // Both requesters held valid continuously; data advances only on accept.
    apply_reset();
    ai = 0;
    li = 0;
    drive_alu(1'b1, a_rd(ai), a_dat(ai));
    drive_lsu(1'b1, l_rd(li), l_dat(li));
    for (int e = 1; e <= 8; e++) begin
      acc_a = wb.alu_ready;
      acc_l = wb.lsu_ready;
      @(negedge clk);
      if (acc_a) ai++;
      if (acc_l) li++;
      drive_alu(1'b1, a_rd(ai), a_dat(ai));
      drive_lsu(1'b1, l_rd(li), l_dat(li));
      if (e == 1) begin
        check("t4.first_wv", 32'(wb.register_write_valid), 32'd0);
      end else begin
        j = e - 2;
`ifdef WB_RR_ARB_EN
        if (j % 2 == 0) check_strobe($sformatf("t4.rr%0d", e), a_rd(j / 2), a_dat(j / 2));
        else            check_strobe($sformatf("t4.rr%0d", e), l_rd(j / 2), l_dat(j / 2));
        if (e == 3) begin
          check("t4.alu_full", 32'(wb.alu_pending), 32'd2);
          check("t4.alu_rdy0", 32'(wb.alu_ready),   32'd0);
        end
`else
        check_strobe($sformatf("t4.fx%0d", e), a_rd(j), a_dat(j));
        check($sformatf("t4.lsu_pend%0d", e), 32'(wb.lsu_pending), 32'd2);
        check($sformatf("t4.lsu_rdy%0d", e),  32'(wb.lsu_ready),   32'd0);
        check($sformatf("t4.alu_pend%0d", e), 32'(wb.alu_pending), 32'd1);
`endif
      end
    end
    drive_alu(1'b0, 5'd0, 32'd0);
`ifdef WB_RR_ARB_EN
    drive_lsu(1'b0, 5'd0, 32'd0);
    repeat (6) @(negedge clk);
    check("t4.drained", 32'(wb.idle), 32'd1);
`else
    // Starved LSU queue drains in order once the ALU goes quiet; l2 was held at the port.
    @(negedge clk);
    check_strobe("t4.a_last", a_rd(7), a_dat(7));
    check("t4.l_full", 32'(wb.lsu_ready), 32'd0);
    @(negedge clk);
    check_strobe("t4.l0", l_rd(0), l_dat(0));
    check("t4.l_rdy", 32'(wb.lsu_ready), 32'd1);
    @(negedge clk);
    check_strobe("t4.l1", l_rd(1), l_dat(1));
    check("t4.l_pend1", 32'(wb.lsu_pending), 32'd1);
    drive_lsu(1'b0, 5'd0, 32'd0);
    @(negedge clk);
    check_strobe("t4.l2", l_rd(2), l_dat(2));
    check("t4.l_pend0", 32'(wb.lsu_pending), 32'd0);
    @(negedge clk);
    check("t4.wv_off", 32'(wb.register_write_valid), 32'd0);
    check("t4.idle",   32'(wb.idle),                 32'd1);
`endif

    // Asynchronous reset with entries queued and a strobe in flight.
    apply_reset();
    drive_alu(1'b1, 5'd3, 32'h33);
    drive_lsu(1'b1, 5'd4, 32'h44);
`ifdef WB_RR_ARB_EN
    repeat (3) @(negedge clk);
    check("t5.pre_alu", 32'(wb.alu_pending), 32'd2);
    check("t5.pre_lsu", 32'(wb.lsu_pending), 32'd1);
`else
    repeat (2) @(negedge clk);
    check("t5.pre_alu", 32'(wb.alu_pending), 32'd1);
    check("t5.pre_lsu", 32'(wb.lsu_pending), 32'd2);
`endif
    check("t5.pre_wv", 32'(wb.register_write_valid), 32'd1);
    drive_alu(1'b0, 5'd0, 32'd0);
    drive_lsu(1'b0, 5'd0, 32'd0);
    #2 reset = 1'b1;
    #1;
    check("t5.wv",       32'(wb.register_write_valid), 32'd0);
    check("t5.rd",       32'(wb.write_reg),            32'd0);
    check("t5.data",     wb.reg_write_data,            32'd0);
    check("t5.alu_pend", 32'(wb.alu_pending),          32'd0);
    check("t5.lsu_pend", 32'(wb.lsu_pending),          32'd0);
    check("t5.alu_rdy",  32'(wb.alu_ready),            32'd1);
    check("t5.lsu_rdy",  32'(wb.lsu_ready),            32'd1);
    check("t5.idle",     32'(wb.idle),                 32'd1);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("t5.no_wv%0d", k), 32'(wb.register_write_valid), 32'd0);
    end
    check("t5.idle_after", 32'(wb.idle), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
